// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path and the FIFO reused by the
// transmitter.
//   rx_state_t       : receiver FSM state encoding
//   PARITY_EVEN/ODD  : legal values of the parity-sense selector
//   STOP_BITS_ONE/TWO: legal stop-bit counts
//   DVSR_W           : width of the baud divisor port
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    localparam bit PARITY_EVEN    = 1'b0;
    localparam bit PARITY_ODD_SEL = 1'b1;

    localparam int STOP_BITS_ONE = 1;
    localparam int STOP_BITS_TWO = 2;

    localparam int DVSR_W = 11;

endpackage

// File: rtl/uart_fifo.sv
// -----------------------------------------------------------------------------
// uart_fifo
// First-word-fall-through FIFO shared by the UART receiver and transmitter.
// Depth is 2**AW; pointers carry one extra bit so full and empty can be told
// apart when the address parts are equal.
//   clk, reset_n : clock, asynchronous active-low reset
//   wr, w_data   : push request and data (ignored when full unless rd is set)
//   rd           : pop request (ignored when empty)
//   r_data       : head word, valid while empty = 0 (reads 0 when empty)
//   empty, full  : occupancy status
// -----------------------------------------------------------------------------
module uart_fifo #(
    parameter int DW = 8,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wr,
    input  logic          rd,
    input  logic [DW-1:0] w_data,
    output logic [DW-1:0] r_data,
    output logic          empty,
    output logic          full
);

    logic [DW-1:0] mem [2**AW];
    logic [AW:0]   w_ptr_reg;
    logic [AW:0]   r_ptr_reg;
    logic          wr_en;
    logic          rd_en;

    assign empty = (w_ptr_reg == r_ptr_reg);
    assign full  = (w_ptr_reg[AW] != r_ptr_reg[AW]) &&
                   (w_ptr_reg[AW-1:0] == r_ptr_reg[AW-1:0]);

    // A write into a full FIFO is still accepted when a pop happens on the
    // same clock: the slot being vacated is the one being filled.
    assign wr_en = wr & (~full | rd);
    assign rd_en = rd & ~empty;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[w_ptr_reg[AW-1:0]] <= w_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w_ptr_reg <= '0;
            r_ptr_reg <= '0;
        end else begin
            if (wr_en) begin
                w_ptr_reg <= w_ptr_reg + {{AW{1'b0}}, 1'b1};
            end
            if (rd_en) begin
                r_ptr_reg <= r_ptr_reg + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Gate the head word so the output is a clean 0 while nothing is stored.
    assign r_data = empty ? '0 : mem[r_ptr_reg[AW-1:0]];

endmodule

// File: rtl/uart_rx_param.sv
// -----------------------------------------------------------------------------
// uart_rx_param
// Oversampling UART receiver with optional parity, 1 or 2 stop bits, a
// receive FIFO and sticky error flags.
//   clk, reset_n  : clock, asynchronous active-low reset
//   dvsr          : baud divisor, one oversampling tick every dvsr+1 clocks
//   rx            : asynchronous serial input, idle high
//   rd_uart       : pop the FIFO head word
//   err_clr       : clear all sticky error flags
//   r_data        : FIFO head word (first-word-fall-through)
//   rx_empty/full : FIFO status
//   rx_done_tick  : one-cycle pulse at the end of every frame, good or bad
//   parity_err, frame_err, overrun_err : sticky error flags
// -----------------------------------------------------------------------------
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DBIT       = 8,
    parameter int OVS        = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_AW    = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DVSR_W-1:0] dvsr,
    input  logic              rx,
    input  logic              rd_uart,
    input  logic              err_clr,
    output logic [DBIT-1:0]   r_data,
    output logic              rx_empty,
    output logic              rx_full,
    output logic              rx_done_tick,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun_err
);

    localparam bit       ODD         = (PARITY_ODD != 0) ? PARITY_ODD_SEL : PARITY_EVEN;
    localparam int       N_STOP      = (STOP_BITS == STOP_BITS_TWO) ? STOP_BITS_TWO : STOP_BITS_ONE;
    localparam logic [3:0] S_HALF      = 4'(OVS / 2 - 1);
    localparam logic [3:0] S_LAST      = 4'(OVS - 1);
    localparam logic [3:0] N_DATA_LAST = 4'(DBIT - 1);
    localparam logic [3:0] N_STOP_LAST = 4'(N_STOP - 1);

    // ------------------------------------------------------------------
    // Input synchroniser, idles at the line's idle level
    // ------------------------------------------------------------------
    logic rx_meta_reg;
    logic rx_sync_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_sync_reg <= rx_meta_reg;
        end
    end

    // ------------------------------------------------------------------
    // Oversampling tick generator. Using >= rather than == means that a
    // divisor lowered below the current count wraps on the next clock
    // instead of running the counter all the way round.
    // ------------------------------------------------------------------
    logic [DVSR_W-1:0] tick_cnt_reg;
    logic              tick;

    assign tick = (tick_cnt_reg >= dvsr);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt_reg <= '0;
        end else if (tick) begin
            tick_cnt_reg <= '0;
        end else begin
            tick_cnt_reg <= tick_cnt_reg + DVSR_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Receiver FSM
    // ------------------------------------------------------------------
    rx_state_t       state_reg, state_next;
    logic [3:0]      s_reg, s_next;
    logic [3:0]      n_reg, n_next;
    logic [DBIT-1:0] shift_reg, shift_next;
    logic            par_bad_reg, par_bad_next;
    logic            stop_bad_reg, stop_bad_next;
    logic            done_tick;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= ST_IDLE;
            s_reg        <= '0;
            n_reg        <= '0;
            shift_reg    <= '0;
            par_bad_reg  <= 1'b0;
            stop_bad_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            s_reg        <= s_next;
            n_reg        <= n_next;
            shift_reg    <= shift_next;
            par_bad_reg  <= par_bad_next;
            stop_bad_reg <= stop_bad_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        s_next        = s_reg;
        n_next        = n_reg;
        shift_next    = shift_reg;
        par_bad_next  = par_bad_reg;
        stop_bad_next = stop_bad_reg;
        done_tick     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (!rx_sync_reg) begin
                    state_next    = ST_START;
                    s_next        = '0;
                    par_bad_next  = 1'b0;
                    stop_bad_next = 1'b0;
                end
            end

            // Re-check the line in the middle of the start bit so that a
            // short glitch is dropped silently.
            ST_START: begin
                if (tick) begin
                    if (s_reg == S_HALF) begin
                        if (!rx_sync_reg) begin
                            state_next = ST_DATA;
                            s_next     = '0;
                            n_next     = '0;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end else begin
                        s_next = s_reg + 4'd1;
                    end
                end
            end

            ST_DATA: begin
                if (tick) begin
                    if (s_reg == S_LAST) begin
                        s_next     = '0;
                        shift_next = {rx_sync_reg, shift_reg[DBIT-1:1]};
                        if (n_reg == N_DATA_LAST) begin
                            n_next     = '0;
                            state_next = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                        end else begin
                            n_next = n_reg + 4'd1;
                        end
                    end else begin
                        s_next = s_reg + 4'd1;
                    end
                end
            end

            ST_PARITY: begin
                if (tick) begin
                    if (s_reg == S_LAST) begin
                        s_next       = '0;
                        par_bad_next = (rx_sync_reg != ((^shift_reg) ^ ODD));
                        state_next   = ST_STOP;
                    end else begin
                        s_next = s_reg + 4'd1;
                    end
                end
            end

            ST_STOP: begin
                if (tick) begin
                    if (s_reg == S_LAST) begin
                        s_next = '0;
                        if (!rx_sync_reg) begin
                            stop_bad_next = 1'b1;
                        end
                        if (n_reg == N_STOP_LAST) begin
                            n_next     = '0;
                            state_next = ST_IDLE;
                            done_tick  = 1'b1;
                        end else begin
                            n_next = n_reg + 4'd1;
                        end
                    end else begin
                        s_next = s_reg + 4'd1;
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign rx_done_tick = done_tick;

    // ------------------------------------------------------------------
    // Frame disposition. The last stop bit is judged from the value being
    // sampled on this very clock, hence stop_bad_next.
    // ------------------------------------------------------------------
    logic frame_good;
    logic par_event;
    logic frame_event;
    logic overrun_event;

    assign frame_good    = done_tick & ~par_bad_reg & ~stop_bad_next;
    assign par_event     = done_tick & par_bad_reg;
    assign frame_event   = done_tick & stop_bad_next;
    assign overrun_event = frame_good & rx_full & ~rd_uart;

    uart_fifo #(
        .DW (DBIT),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr      (frame_good),
        .rd      (rd_uart),
        .w_data  (shift_reg),
        .r_data  (r_data),
        .empty   (rx_empty),
        .full    (rx_full)
    );

    // Sticky flags: a new error event on the clearing clock keeps the flag set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            if (par_event) begin
                parity_err <= 1'b1;
            end else if (err_clr) begin
                parity_err <= 1'b0;
            end
            if (frame_event) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end
            if (overrun_event) begin
                overrun_err <= 1'b1;
            end else if (err_clr) begin
                overrun_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_param
// Two receivers share clock, reset, divisor and err_clr:
//   unit 0 : 8 data bits, no parity, 1 stop bit, 4-deep FIFO
//   unit 1 : 8 data bits, even parity, 2 stop bits, 4-deep FIFO
// Frames are generated bit by bit; a queue per unit plus expected flag values
// model what the receiver must report after each frame.
// -----------------------------------------------------------------------------
module tb_uart_rx_param;

    localparam int DEPTH = 4;
    localparam int OVS   = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [10:0] dvsr;
    logic        err_clr;
    logic        rx_line  [2];
    logic        rd_req   [2];
    logic [7:0]  r_data_o [2];
    logic        empty_o  [2];
    logic        full_o   [2];
    logic        done_o   [2];
    logic        perr_o   [2];
    logic        ferr_o   [2];
    logic        oerr_o   [2];

    always #5 clk = ~clk;

    uart_rx_param #(
        .DBIT(8), .OVS(OVS), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1), .FIFO_AW(2)
    ) dut0 (
        .clk(clk), .reset_n(reset_n), .dvsr(dvsr), .rx(rx_line[0]), .rd_uart(rd_req[0]),
        .err_clr(err_clr), .r_data(r_data_o[0]), .rx_empty(empty_o[0]), .rx_full(full_o[0]),
        .rx_done_tick(done_o[0]), .parity_err(perr_o[0]), .frame_err(ferr_o[0]),
        .overrun_err(oerr_o[0])
    );

    uart_rx_param #(
        .DBIT(8), .OVS(OVS), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2), .FIFO_AW(2)
    ) dut1 (
        .clk(clk), .reset_n(reset_n), .dvsr(dvsr), .rx(rx_line[1]), .rd_uart(rd_req[1]),
        .err_clr(err_clr), .r_data(r_data_o[1]), .rx_empty(empty_o[1]), .rx_full(full_o[1]),
        .rx_done_tick(done_o[1]), .parity_err(perr_o[1]), .frame_err(ferr_o[1]),
        .overrun_err(oerr_o[1])
    );

    // ---------------- reference model state ----------------
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    bit         exp_perr [2];
    bit         exp_ferr [2];
    bit         exp_oerr [2];
    int         exp_done [2];
    int         done_cnt [2];
    int         n_checks = 0;
    int         n_errors = 0;

    initial begin
        done_cnt[0] = 0;
        done_cnt[1] = 0;
    end

    always @(negedge clk) begin
        if (done_o[0] === 1'b1) done_cnt[0] <= done_cnt[0] + 1;
        if (done_o[1] === 1'b1) done_cnt[1] <= done_cnt[1] + 1;
    end

    initial begin
        #10000000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int q_size(input int u);
        return (u == 0) ? q0.size() : q1.size();
    endfunction

    function automatic int q_front(input int u);
        return (u == 0) ? int'(q0[0]) : int'(q1[0]);
    endfunction

    task automatic q_push(input int u, input logic [7:0] d);
        if (u == 0) q0.push_back(d);
        else        q1.push_back(d);
    endtask

    task automatic q_pop(input int u);
        if (u == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
    endtask

    task automatic clear_flags();
        for (int k = 0; k < 2; k++) begin
            exp_perr[k] = 1'b0;
            exp_ferr[k] = 1'b0;
            exp_oerr[k] = 1'b0;
        end
    endtask

    task automatic check_unit(input int u);
        string p;
        p = $sformatf("u%0d ", u);
        check({p, "done_count"},  done_cnt[u], exp_done[u]);
        check({p, "rx_empty"},    int'(empty_o[u]), int'(q_size(u) == 0));
        check({p, "rx_full"},     int'(full_o[u]),  int'(q_size(u) == DEPTH));
        check({p, "parity_err"},  int'(perr_o[u]),  int'(exp_perr[u]));
        check({p, "frame_err"},   int'(ferr_o[u]),  int'(exp_ferr[u]));
        check({p, "overrun_err"}, int'(oerr_o[u]),  int'(exp_oerr[u]));
        if (q_size(u) > 0) check({p, "r_data"}, int'(r_data_o[u]), q_front(u));
    endtask

    task automatic check_reset(input int u);
        string p;
        p = $sformatf("u%0d rst ", u);
        check({p, "r_data"},      int'(r_data_o[u]), 0);
        check({p, "rx_empty"},    int'(empty_o[u]), 1);
        check({p, "rx_full"},     int'(full_o[u]), 0);
        check({p, "done_tick"},   int'(done_o[u]), 0);
        check({p, "parity_err"},  int'(perr_o[u]), 0);
        check({p, "frame_err"},   int'(ferr_o[u]), 0);
        check({p, "overrun_err"}, int'(oerr_o[u]), 0);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive(input int u, input logic b, input int n);
        rx_line[u] = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // bad_stop: index of the stop bit driven low, -1 for none. A low stop bit
    // returns high for the last quarter of its slot so the line is idle well
    // before the receiver re-checks a start condition.
    task automatic send_frame(input int u, input logic [7:0] d, input bit par_ok, input int bad_stop);
        int bc;
        int nstop;
        bc    = OVS * (int'(dvsr) + 1);
        nstop = (u == 1) ? 2 : 1;
        drive(u, 1'b0, bc);
        for (int i = 0; i < 8; i++) drive(u, d[i], bc);
        if (u == 1) drive(u, (^d) ^ !par_ok, bc);
        for (int k = 0; k < nstop; k++) begin
            if (k == bad_stop) begin
                drive(u, 1'b0, bc * 3 / 4);
                drive(u, 1'b1, bc - bc * 3 / 4);
            end else begin
                drive(u, 1'b1, bc);
            end
        end
        drive(u, 1'b1, bc);
    endtask

    // mode 1: err_clr on the done cycle, mode 2: rd_uart on the done cycle
    task automatic at_done(input int u, input int mode);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20000 && !seen; i++) begin
            @(negedge clk);
            if (done_o[u] === 1'b1) seen = 1'b1;
        end
        if (seen) begin
            if (mode == 1) err_clr = 1'b1;
            else           rd_req[u] = 1'b1;
            @(posedge clk);
            #1;
            err_clr   = 1'b0;
            rd_req[u] = 1'b0;
        end
        check($sformatf("u%0d done_seen", u), int'(seen), 1);
    endtask

    task automatic model_frame(input int u, input logic [7:0] d, input bit par_ok,
                               input int bad_stop, input int mode);
        bit p_bad;
        p_bad = (u == 1) && !par_ok;
        if (mode == 1) clear_flags();
        if (mode == 2 && q_size(u) > 0) q_pop(u);
        if (!p_bad && bad_stop < 0) begin
            if (q_size(u) < DEPTH) q_push(u, d);
            else                   exp_oerr[u] = 1'b1;
        end else begin
            if (p_bad)         exp_perr[u] = 1'b1;
            if (bad_stop >= 0) exp_ferr[u] = 1'b1;
        end
        exp_done[u]++;
    endtask

    task automatic do_frame(input int u, input logic [7:0] d, input bit par_ok,
                            input int bad_stop, input int mode);
        $display("u%0d frame data=%02h par_ok=%0d bad_stop=%0d mode=%0d dvsr=%0d",
                 u, d, par_ok, bad_stop, mode, dvsr);
        if (mode == 0) begin
            send_frame(u, d, par_ok, bad_stop);
        end else begin
            fork
                send_frame(u, d, par_ok, bad_stop);
                at_done(u, mode);
            join
        end
        model_frame(u, d, par_ok, bad_stop, mode);
        check_unit(u);
    endtask

    task automatic pop(input int u);
        $display("u%0d pop size=%0d", u, q_size(u));
        if (q_size(u) > 0) check($sformatf("u%0d pop_head", u), int'(r_data_o[u]), q_front(u));
        rd_req[u] = 1'b1;
        @(posedge clk);
        #1;
        rd_req[u] = 1'b0;
        if (q_size(u) > 0) q_pop(u);
        check_unit(u);
    endtask

    task automatic pulse_clr();
        $display("err_clr pulse");
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        clear_flags();
        check_unit(0);
        check_unit(1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int bc;
        reset_n   = 1'b0;
        dvsr      = '0;
        err_clr   = 1'b0;
        rx_line[0] = 1'b1;
        rx_line[1] = 1'b1;
        rd_req[0]  = 1'b0;
        rd_req[1]  = 1'b0;
        exp_done[0] = 0;
        exp_done[1] = 0;
        clear_flags();
        repeat (3) @(posedge clk);
        #1;
        check_reset(0);
        check_reset(1);
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_unit(0);
        check_unit(1);

        // 0xCD = bits 1,0,1,1,0,0,1,1 LSB first, then drain it
        do_frame(0, 8'hCD, 1'b1, -1, 0);
        pop(0);

        // 6-clock glitch: false start
        $display("u0 false start 6 clocks");
        drive(0, 1'b0, 6);
        drive(0, 1'b1, 48);
        check_unit(0);

        // wrong even parity bit for 0xCD, then clear
        do_frame(1, 8'hCD, 1'b0, -1, 0);
        pulse_clr();

        // framing error, then a good 0x55
        do_frame(0, 8'h3C, 1'b1, 0, 0);
        do_frame(0, 8'h55, 1'b1, -1, 0);
        pop(0);

        // err_clr on the same clock as a framing error: flag stays set
        do_frame(0, 8'h0F, 1'b1, 0, 1);
        pulse_clr();

        // five frames into a 4-deep FIFO
        for (int i = 1; i <= 5; i++) do_frame(0, 8'(i), 1'b1, -1, 0);
        for (int i = 0; i < 4; i++) pop(0);
        pop(0);
        pulse_clr();

        // write and read on the same clock while full
        for (int i = 0; i < 4; i++) do_frame(0, 8'(8'h10 + i), 1'b1, -1, 0);
        do_frame(0, 8'h14, 1'b1, -1, 2);

        // second stop bit low on the 2-stop-bit unit
        do_frame(1, 8'hA0, 1'b1, 1, 0);

        // reset in the middle of data bit 4
        $display("u0 reset during data bit 4");
        bc = OVS * (int'(dvsr) + 1);
        fork
            send_frame(0, 8'hFF, 1'b1, -1);
            begin
                repeat (bc * 5 + bc / 2) @(posedge clk);
                #3;
                reset_n = 1'b0;
                #1;
                check_reset(0);
                check_reset(1);
            end
        join
        reset_n = 1'b1;
        q0.delete();
        q1.delete();
        clear_flags();
        repeat (4) @(posedge clk);
        #1;
        check_unit(0);
        check_unit(1);
        do_frame(0, 8'hA5, 1'b1, -1, 0);
        pop(0);

        // randomized traffic
        for (int t = 0; t < 40; t++) begin
            int   u;
            int   nstop;
            int   bad_stop;
            int   mode;
            bit   par_ok;
            logic [7:0] d;
            u = $urandom_range(0, 1);
            if ($urandom_range(0, 3) == 0) begin
                dvsr = 11'($urandom_range(0, 3));
                $display("dvsr set to %0d", dvsr);
                repeat (2 * OVS * (int'(dvsr) + 1)) @(posedge clk);
                #1;
            end
            nstop    = (u == 1) ? 2 : 1;
            d        = 8'($urandom);
            par_ok   = ($urandom_range(0, 5) != 0);
            bad_stop = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, nstop - 1)) : -1;
            mode     = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0;
            do_frame(u, d, par_ok, bad_stop, mode);
            for (int k = $urandom_range(0, 2); k > 0; k--) pop(u);
            if ($urandom_range(0, 7) == 0) pulse_clr();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL have parameter DBIT, default 8, data bits per frame (legal 5..9).
REQ-002 SHALL have parameter OVS, default 16, baud-tick oversampling factor (even, legal 8..16).
REQ-003 SHALL have parameter PARITY_EN, default 0, 1 = parity bit expected after data.
REQ-004 SHALL have parameter PARITY_ODD, default 0, 1 = odd parity, 0 = even; ignored when PARITY_EN = 0.
REQ-005 SHALL have parameter STOP_BITS, default 1, stop bits checked (1 or 2).
REQ-006 SHALL have parameter FIFO_AW, default 2, FIFO address width; depth = 2**FIFO_AW.
REQ-007 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-008 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-009 SHALL have port dvsr  input  11  baud divisor; one baud tick every dvsr+1 clocks.
REQ-010 SHALL have port rx  input  1  asynchronous serial input, idle high.
REQ-011 SHALL have port rd_uart  input  1  pop request; head word removed on this clock.
REQ-012 SHALL have port err_clr  input  1  one-cycle pulse clearing all sticky error flags.
REQ-013 SHALL have port r_data  output  DBIT  FIFO head word (first-word-fall-through).
REQ-014 SHALL have port rx_empty  output  1  FIFO empty.
REQ-015 SHALL have port rx_full  output  1  FIFO full.
REQ-016 SHALL have port rx_done_tick  output  1  one-cycle pulse on each frame completion (good or bad).
REQ-017 SHALL have ports parity_err, frame_err, overrun_err  output  1 each  sticky error flags.

Function
REQ-018 rx SHALL pass a 2-flop synchroniser; FSM uses only the synchronised value.
REQ-019 Tick counter SHALL count 0..dvsr and assert tick when count = dvsr; dvsr = 0 gives a tick every clock.
REQ-020 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; per-bit tick counter s and bit counter n.
REQ-021 IDLE -> START on synchronised rx = 0; s cleared.
REQ-022 START: at tick with s = OVS/2-1, rx = 0 -> DATA (s, n cleared); rx = 1 -> IDLE (false start, no flag, no done tick).
REQ-023 DATA: at tick with s = OVS-1, sample rx into shift register LSB first; after DBIT bits -> PARITY if PARITY_EN else STOP.
REQ-024 PARITY: sample at s = OVS-1; mismatch with XOR(data) ^ PARITY_ODD marks frame parity-bad.
REQ-025 STOP: sample each stop bit at s = OVS-1; any 0 marks frame framing-bad; after STOP_BITS bits -> IDLE and pulse rx_done_tick.
REQ-026 Good frame SHALL be written to FIFO on the rx_done_tick cycle; parity- or framing-bad frames SHALL be discarded and set parity_err / frame_err.
REQ-027 Good frame while FIFO full and rd_uart = 0 SHALL be dropped and set overrun_err; FIFO content unchanged.
REQ-028 Simultaneous write and rd_uart with FIFO full SHALL accept both; occupancy unchanged.
REQ-029 rd_uart while empty SHALL be ignored; pointers unchanged.
REQ-030 rx_empty SHALL deassert the clock after the write; r_data valid whenever rx_empty = 0.
REQ-031 Pointers SHALL wrap modulo 2**FIFO_AW; full/empty distinguished by an extra pointer bit.
REQ-032 err_clr SHALL clear flags; an error event in the same cycle SHALL win (flag stays 1).
REQ-033 dvsr changes mid-frame SHALL take effect at next tick-counter wrap; no other guarantee.

Reset
REQ-034 reset_n low SHALL immediately force FSM IDLE, counters 0, FIFO empty, synchroniser to 1.
REQ-035 Reset values: r_data 0, rx_empty 1, rx_full 0, rx_done_tick 0, all error flags 0.
REQ-036 Reset mid-frame SHALL abandon the frame with no write and no flag.

Structure
REQ-037 Package uart_pkg SHALL hold the rx state enum and parity/stop legal-value constants.
REQ-038 FIFO SHALL be a separate sub-module uart_fifo (parameters DW, AW), reusable by the transmitter.

Verification
REQ-039 dvsr=0, defaults, frame start + bits 1,0,1,1,0,0,1,1 LSB first + stop, 16 clocks/bit -> rx_done_tick once, r_data = 0xCD, rx_empty 0; rd_uart pulse -> rx_empty 1.
REQ-040 rx low 6 clocks then high, dvsr=0 -> returns IDLE, no done tick, no write, no flags.
REQ-041 PARITY_EN=1 even, send 0xCD with parity bit 0 (wrong, 5 ones) -> parity_err 1, FIFO empty; err_clr -> parity_err 0.
REQ-042 Stop bit driven 0 -> frame_err 1, no write; following good frame 0x55 received correctly.
REQ-043 FIFO_AW=2, five good frames 0x01..0x05 without reads -> rx_full 1, overrun_err 1, reads return 0x01..0x04.
REQ-044 reset_n asserted during DATA bit 4 -> all outputs at reset values; next frame 0xA5 received intact.
